// File: rtl/gemm_insn_issue.sv
// rtl/gemm_insn_issue.sv - GEMM instruction issue stage: FIFO, dependency tokens, exec timing
//
// Buffers GEMM instructions in a small FIFO and resolves pop_prev/pop_next tokens.
// It holds each GEMM instruction on insn_out for its micro-op cycle count and then
// drives zero while the core pipeline drains. After that it pulses done and the
// push tokens.
// Optional feature macro: GEMM_ISSUE_PERF_EN (perf_exec_cycles, perf_stall_cycles, perf_clr).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   insn_in/insn_valid  instruction from command queue; insn_ready = FIFO not full
//   insn_out            instruction to GEMM core, zero when not executing
//   busy                high in WAIT_DEP, EXEC, DRAIN, DONE
//   done                one-cycle pulse per retired instruction
//   l2g_dep_valid/ready load-to-gemm token available / pop pulse
//   s2g_dep_valid/ready store-to-gemm token available / pop pulse
//   g2l_dep_push        gemm-to-load token push pulse
//   g2s_dep_push        gemm-to-store token push pulse
//   perf_*              (GEMM_ISSUE_PERF_EN only) saturating perf counters, sync clear
module gemm_insn_issue #(
    parameter int INS_WIDTH    = 128,
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 41
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INS_WIDTH-1:0] insn_in,
    input  logic                 insn_valid,
    output logic                 insn_ready,
    output logic [INS_WIDTH-1:0] insn_out,
    output logic                 busy,
    output logic                 done,
    input  logic                 l2g_dep_valid,
    output logic                 l2g_dep_ready,
    input  logic                 s2g_dep_valid,
    output logic                 s2g_dep_ready,
    output logic                 g2l_dep_push,
    output logic                 g2s_dep_push
`ifdef GEMM_ISSUE_PERF_EN
    ,
    input  logic                 perf_clr,
    output logic [31:0]          perf_exec_cycles,
    output logic [31:0]          perf_stall_cycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0] OP_GEMM = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DEP,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;

    // ---------------- instruction FIFO ----------------
    logic [INS_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        count_next;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic [INS_WIDTH-1:0] fifo_head;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_head  = fifo_mem[rd_ptr];
    assign fifo_push  = insn_valid && insn_ready;
    // The FSM takes the head whenever it is ready for a new instruction.
    assign fifo_pop   = !fifo_empty && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        count_next = fifo_count;
        if (fifo_push && !fifo_pop) begin
            count_next = fifo_count + CW'(1);
        end else if (!fifo_push && fifo_pop) begin
            count_next = fifo_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= insn_in;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            insn_ready <= 1'b1;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_next;
            insn_ready <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    // ---------------- current instruction decode ----------------
    logic [INS_WIDTH-1:0] cur_insn;
    logic [2:0]           opcode;
    logic                 pop_prev;
    logic                 pop_next;
    logic                 push_prev;
    logic                 push_next;
    logic [12:0]          uop_bgn;
    logic [13:0]          uop_end;
    logic [13:0]          iter_out;
    logic [13:0]          iter_in;
    logic [13:0]          uop_len;
    logic [CNT_WIDTH-1:0] exec_n;
    logic                 deps_ok;

    assign opcode    = cur_insn[2:0];
    assign pop_prev  = cur_insn[3];
    assign pop_next  = cur_insn[4];
    assign push_prev = cur_insn[5];
    assign push_next = cur_insn[6];
    assign uop_bgn   = cur_insn[20:8];
    assign uop_end   = cur_insn[34:21];
    assign iter_out  = cur_insn[48:35];
    assign iter_in   = cur_insn[62:49];

    // An empty or inverted micro-op range contributes zero length rather than wrapping.
    assign uop_len = (uop_end > {1'b0, uop_bgn}) ? (uop_end - {1'b0, uop_bgn}) : 14'd0;
    assign exec_n  = CNT_WIDTH'(iter_out) * CNT_WIDTH'(iter_in) * CNT_WIDTH'(uop_len);

    assign deps_ok = (!pop_prev || l2g_dep_valid) && (!pop_next || s2g_dep_valid);

    // Token pops happen in the same cycle that all required tokens are seen.
    assign l2g_dep_ready = (state == S_WAIT_DEP) && deps_ok && pop_prev;
    assign s2g_dep_ready = (state == S_WAIT_DEP) && deps_ok && pop_next;
    assign busy          = (state != S_IDLE);

    // ---------------- sequencing FSM ----------------
    // cnt counts EXEC cycles down to 1 and then counts DRAIN cycles down to 0.
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cur_insn     <= '0;
            cnt          <= '0;
            insn_out     <= '0;
            done         <= 1'b0;
            g2l_dep_push <= 1'b0;
            g2s_dep_push <= 1'b0;
        end else begin
            done         <= 1'b0;
            g2l_dep_push <= 1'b0;
            g2s_dep_push <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cur_insn <= fifo_head;
                        state    <= S_WAIT_DEP;
                    end
                end
                S_WAIT_DEP: begin
                    if (deps_ok) begin
                        if ((opcode != OP_GEMM) || (exec_n == '0)) begin
                            state        <= S_DONE;
                            done         <= 1'b1;
                            g2l_dep_push <= push_prev;
                            g2s_dep_push <= push_next;
                        end else begin
                            cnt      <= exec_n;
                            insn_out <= cur_insn;
                            state    <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt == CNT_WIDTH'(1)) begin
                        insn_out <= '0;
                        cnt      <= CNT_WIDTH'(DRAIN_CYCLES - 1);
                        state    <= S_DRAIN;
                    end else begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt == '0) begin
                        state        <= S_DONE;
                        done         <= 1'b1;
                        g2l_dep_push <= push_prev;
                        g2s_dep_push <= push_next;
                    end else begin
                        cnt <= cnt - CNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    // Back-to-back: skip IDLE when another instruction is queued.
                    if (!fifo_empty) begin
                        cur_insn <= fifo_head;
                        state    <= S_WAIT_DEP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef GEMM_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_exec_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else if (perf_clr) begin
            perf_exec_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if ((state == S_EXEC) && (perf_exec_cycles != 32'hFFFF_FFFF)) begin
                perf_exec_cycles <= perf_exec_cycles + 32'd1;
            end
            if ((state == S_WAIT_DEP) && !deps_ok && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gemm_insn_issue.sv
// tb/tb_gemm_insn_issue.sv - self-checking bench for gemm_insn_issue
module tb_gemm_insn_issue;
    localparam int DEPTH = 4;
    localparam int DRAIN = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] insn_in;
    logic         insn_valid;
    logic         insn_ready;
    logic [127:0] insn_out;
    logic         busy;
    logic         done;
    logic         l2g_dep_valid;
    logic         l2g_dep_ready;
    logic         s2g_dep_valid;
    logic         s2g_dep_ready;
    logic         g2l_dep_push;
    logic         g2s_dep_push;

    int err = 0;
    int chk = 0;

    always #5 clk = ~clk;

    gemm_insn_issue #(
        .INS_WIDTH(128), .FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .CNT_WIDTH(41)
    ) dut (
        .clk(clk), .rst(rst),
        .insn_in(insn_in), .insn_valid(insn_valid), .insn_ready(insn_ready),
        .insn_out(insn_out), .busy(busy), .done(done),
        .l2g_dep_valid(l2g_dep_valid), .l2g_dep_ready(l2g_dep_ready),
        .s2g_dep_valid(s2g_dep_valid), .s2g_dep_ready(s2g_dep_ready),
        .g2l_dep_push(g2l_dep_push), .g2s_dep_push(g2s_dep_push)
    );

    // ---------------- reference model ----------------
    function automatic logic [127:0] mk(input logic [2:0] op, input bit pp, input bit pn,
                                        input bit sp, input bit sn, input int bgn,
                                        input int en, input int io, input int ii);
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        v[2:0] = op; v[3] = pp; v[4] = pn; v[5] = sp; v[6] = sn;
        v[20:8] = 13'(bgn); v[34:21] = 14'(en); v[48:35] = 14'(io); v[62:49] = 14'(ii);
        return v;
    endfunction

    // Micro-op cycle count: iterations times range length, zero for non-GEMM.
    function automatic longint unsigned model_n(input logic [127:0] v);
        longint unsigned b, e, io, ii, len;
        if (v[2:0] != 3'b010) return 0;
        b = v[20:8]; e = v[34:21]; io = v[48:35]; ii = v[62:49];
        len = (e > b) ? e - b : 0;
        return (io * ii * len) & 64'h1FF_FFFF_FFFF;
    endfunction

    // ---------------- retirement monitor ----------------
    logic [127:0] rec_val [512];
    int           rec_len [512];
    bit           rec_g2l [512];
    bit           rec_g2s [512];
    bit           rec_bad [512];
    int           rec_n = 0;
    int           l2g_pulses = 0;
    int           s2g_pulses = 0;
    logic [127:0] run_val = '0;
    logic [127:0] last_val = '0;
    int           run_len = 0;
    int           last_len = 0;
    bit           run_bad = 0;
    bit           last_bad = 0;

    always @(negedge clk) begin
        if (!rst) begin
            run_len = 0; last_len = 0; run_bad = 0; last_bad = 0; last_val = '0;
        end else begin
            if (l2g_dep_ready) l2g_pulses++;
            if (s2g_dep_ready) s2g_pulses++;
            if (insn_out != '0) begin
                if (run_len == 0) run_val = insn_out;
                else if (insn_out !== run_val) run_bad = 1;
                run_len++;
            end else if (run_len != 0) begin
                last_val = run_val; last_len = run_len; last_bad = run_bad;
                run_len = 0; run_bad = 0;
            end
            if (done) begin
                if (rec_n < 512) begin
                    rec_val[rec_n] = last_val; rec_len[rec_n] = last_len;
                    rec_g2l[rec_n] = g2l_dep_push; rec_g2s[rec_n] = g2s_dep_push;
                    rec_bad[rec_n] = last_bad;
                end
                rec_n++;
                last_len = 0; last_val = '0; last_bad = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [127:0] obs_out  [64];
    bit           obs_busy [64];
    bit           obs_done [64];
    bit           obs_g2l  [64];
    bit           obs_g2s  [64];
    bit           obs_rdy  [64];

    // All tasks start and end at posedge + 1.
    task automatic send(input logic [127:0] d);
        int t = 0;
        insn_in = d; insn_valid = 1'b1;
        while (!insn_ready && t < 3000) begin @(posedge clk); #1; t++; end
        chk++;
        if (t >= 3000) begin err++; $display("FAIL send_timeout ready=%0b required=1", insn_ready); end
        @(posedge clk); #1;
        insn_valid = 1'b0;
    endtask

    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_out[i] = insn_out; obs_busy[i] = busy; obs_done[i] = done;
            obs_g2l[i] = g2l_dep_push; obs_g2s[i] = g2s_dep_push; obs_rdy[i] = insn_ready;
        end
        @(posedge clk); #1;
    endtask

    task automatic analyze(input int n, input logic [127:0] v, output int f_exec, output int e_len,
                           output int d_idx, output int b_cnt, output int d_cnt, output int bad);
        f_exec = -1; e_len = 0; d_idx = -1; b_cnt = 0; d_cnt = 0; bad = 0;
        for (int i = 0; i < n; i++) begin
            if (obs_out[i] != '0) begin
                if (f_exec < 0) f_exec = i;
                if (obs_out[i] !== v || i != f_exec + e_len) bad++;
                e_len++;
            end
            if (obs_busy[i]) b_cnt++;
            if (obs_done[i]) begin d_cnt++; if (d_idx < 0) d_idx = i; end
        end
    endtask

    task automatic wait_done(output bit ok);
        int t = 0;
        ok = 0;
        while (t < 3000) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
            t++;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk++; if (insn_ready !== 1'b1) begin err++; $display("FAIL reset_ready got=%0b exp=1", insn_ready); end
        chk++; if (insn_out !== '0) begin err++; $display("FAIL reset_insn_out got=%h exp=0", insn_out); end
        chk++;
        if ({busy, done, l2g_dep_ready, s2g_dep_ready, g2l_dep_push, g2s_dep_push} !== 6'b0) begin
            err++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {busy, done, l2g_dep_ready, s2g_dep_ready, g2l_dep_push, g2s_dep_push});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_gemm_exec;
        logic [127:0] v;
        longint unsigned n;
        int fe, el, di, bc, dc, bad;
        v = mk(3'b010, 0, 0, 0, 0, 0, 4, 2, 3);
        n = model_n(v);
        send(v);
        observe(40);
        analyze(40, v, fe, el, di, bc, dc, bad);
        chk++; if (longint'(el) != n) begin err++; $display("FAIL exec_len got=%0d exp=%0d", el, n); end
        chk++; if (bad != 0) begin err++; $display("FAIL exec_hold got=%0d exp=0", bad); end
        chk++; if (fe != 2) begin err++; $display("FAIL exec_start got=%0d exp=2", fe); end
        chk++; if (di - (fe + el) != DRAIN) begin err++; $display("FAIL drain_len got=%0d exp=%0d", di - (fe + el), DRAIN); end
        chk++; if (longint'(bc) != n + DRAIN + 2) begin err++; $display("FAIL busy_len got=%0d exp=%0d", bc, n + DRAIN + 2); end
        chk++; if (dc != 1) begin err++; $display("FAIL done_cnt got=%0d exp=1", dc); end
    endtask

    task automatic test_dep_wait;
        logic [127:0] v;
        int bad = 0;
        int l0 = l2g_pulses;
        int s0 = s2g_pulses;
        bit ok;
        v = mk(3'b010, 1, 0, 0, 0, 0, 2, 1, 1);
        send(v);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (insn_out !== '0 || l2g_dep_ready !== 1'b0) bad++;
        end
        chk++; if (bad != 0) begin err++; $display("FAIL dep_stall got=%0d exp=0", bad); end
        @(posedge clk); #1;
        l2g_dep_valid = 1'b1;
        @(negedge clk);
        chk++; if (l2g_dep_ready !== 1'b1) begin err++; $display("FAIL dep_pop got=%0b exp=1", l2g_dep_ready); end
        @(posedge clk); #1;
        l2g_dep_valid = 1'b0;
        @(negedge clk);
        chk++; if (insn_out !== v) begin err++; $display("FAIL dep_exec got=%h exp=%h", insn_out, v); end
        @(posedge clk); #1;
        wait_done(ok);
        chk++; if (!ok) begin err++; $display("FAIL dep_done got=timeout exp=done"); end
        chk++;
        if (l2g_pulses - l0 != 1 || s2g_pulses - s0 != 0) begin
            err++; $display("FAIL dep_pulses got=%0d/%0d exp=1/0", l2g_pulses - l0, s2g_pulses - s0);
        end
    endtask

    task automatic test_zero_len;
        logic [127:0] v;
        int fe, el, di, bc, dc, bad;
        v = mk(3'b010, 0, 0, 0, 1, 5, 5, 7, 9);
        send(v);
        observe(12);
        analyze(12, v, fe, el, di, bc, dc, bad);
        chk++; if (el != 0) begin err++; $display("FAIL zl_exec got=%0d exp=0", el); end
        chk++; if (di != 2) begin err++; $display("FAIL zl_done_idx got=%0d exp=2", di); end
        chk++;
        if (di >= 0 && (obs_g2s[di] !== 1'b1 || obs_g2l[di] !== 1'b0)) begin
            err++; $display("FAIL zl_push got=%0b%0b exp=01", obs_g2l[di], obs_g2s[di]);
        end
        chk++; if (bc != 2) begin err++; $display("FAIL zl_busy got=%0d exp=2", bc); end
    endtask

    task automatic test_non_gemm;
        logic [127:0] v;
        int fe, el, di, bc, dc, bad;
        v = mk(3'b000, 0, 0, 1, 0, 0, 4, 2, 3);
        send(v);
        observe(12);
        analyze(12, v, fe, el, di, bc, dc, bad);
        chk++; if (el != 0) begin err++; $display("FAIL ld_exec got=%0d exp=0", el); end
        chk++; if (di != 2 || dc != 1) begin err++; $display("FAIL ld_done got=%0d/%0d exp=2/1", di, dc); end
        chk++;
        if (di >= 0 && (obs_g2l[di] !== 1'b1 || obs_g2s[di] !== 1'b0)) begin
            err++; $display("FAIL ld_push got=%0b%0b exp=10", obs_g2l[di], obs_g2s[di]);
        end
    endtask

    logic [127:0] bb_v [5];
    int  bb_busy, bb_gaps, bb_dones;
    bit  bb_full;

    task automatic test_back_to_back;
        longint unsigned tot = 0;
        int base = rec_n;
        bit started = 0;
        for (int i = 0; i < 5; i++) begin
            bb_v[i] = mk(3'b010, 0, 0, 1'($urandom % 2), 1'($urandom % 2), 0, 2, 1, i + 1);
            tot += model_n(bb_v[i]) + DRAIN + 2;
        end
        bb_busy = 0; bb_gaps = 0; bb_dones = 0; bb_full = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(bb_v[i]);
                bb_full = !insn_ready;
            end
            begin
                for (int t = 0; t < 3000 && bb_dones < 5; t++) begin
                    @(negedge clk);
                    if (busy) begin started = 1; bb_busy++; end
                    else if (started) bb_gaps++;
                    if (done) bb_dones++;
                end
                @(posedge clk); #1;
            end
        join
        chk++; if (!bb_full) begin err++; $display("FAIL b2b_full got=ready exp=not_ready"); end
        chk++; if (bb_dones != 5) begin err++; $display("FAIL b2b_dones got=%0d exp=5", bb_dones); end
        chk++; if (bb_gaps != 0) begin err++; $display("FAIL b2b_gaps got=%0d exp=0", bb_gaps); end
        chk++; if (longint'(bb_busy) != tot) begin err++; $display("FAIL b2b_busy got=%0d exp=%0d", bb_busy, tot); end
        for (int i = 0; i < 5; i++) begin
            chk++;
            if (rec_val[base + i] !== bb_v[i] || longint'(rec_len[base + i]) != model_n(bb_v[i]) ||
                rec_g2l[base + i] != bb_v[i][5] || rec_g2s[base + i] != bb_v[i][6] || rec_bad[base + i]) begin
                err++;
                $display("FAIL b2b_rec%0d got=%h/%0d/%0b%0b exp=%h/%0d/%0b%0b", i, rec_val[base + i],
                         rec_len[base + i], rec_g2l[base + i], rec_g2s[base + i], bb_v[i],
                         model_n(bb_v[i]), bb_v[i][5], bb_v[i][6]);
            end
        end
    endtask

    task automatic test_reset_mid_exec;
        logic [127:0] v;
        int t = 0;
        int base;
        int bad = 0;
        v = mk(3'b010, 0, 0, 1, 1, 0, 4, 2, 3);
        send(v);
        while (insn_out == '0 && t < 100) begin @(negedge clk); t++; end
        chk++; if (t >= 100) begin err++; $display("FAIL rm_start got=timeout exp=exec"); end
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk++; if (insn_out !== '0) begin err++; $display("FAIL rm_async_out got=%h exp=0", insn_out); end
        chk++;
        if (insn_ready !== 1'b1 || busy !== 1'b0) begin
            err++; $display("FAIL rm_state got=rdy%0b busy%0b exp=rdy1 busy0", insn_ready, busy);
        end
        base = rec_n;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        observe(40);
        for (int i = 0; i < 40; i++) begin
            if (obs_done[i] || obs_g2l[i] || obs_g2s[i] || obs_busy[i] || !obs_rdy[i] || obs_out[i] != '0) bad++;
        end
        chk++; if (bad != 0 || rec_n != base) begin err++; $display("FAIL rm_quiet got=%0d exp=0", bad); end
    endtask

    bit           rnd_active;
    logic [127:0] rnd_q [30];

    task automatic test_random;
        int base = rec_n;
        int l0 = l2g_pulses;
        int s0 = s2g_pulses;
        int exp_l = 0;
        int exp_s = 0;
        int t = 0;
        logic [2:0] op;
        for (int i = 0; i < 30; i++) begin
            op = ($urandom % 4 == 0) ? 3'($urandom_range(3, 7)) : 3'b010;
            rnd_q[i] = mk(op, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
            exp_l += rnd_q[i][3];
            exp_s += rnd_q[i][4];
        end
        rnd_active = 1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    send(rnd_q[i]);
                end
                while (rec_n < base + 30 && t < 20000) begin @(posedge clk); #1; t++; end
                rnd_active = 0;
            end
            begin
                while (rnd_active) begin
                    @(posedge clk); #1;
                    l2g_dep_valid = 1'($urandom % 2);
                    s2g_dep_valid = 1'($urandom % 2);
                end
            end
        join
        l2g_dep_valid = 1'b0; s2g_dep_valid = 1'b0;
        chk++; if (rec_n != base + 30) begin err++; $display("FAIL rnd_count got=%0d exp=30", rec_n - base); end
        for (int i = 0; i < 30; i++) begin
            chk++;
            if (rec_val[base + i] !== ((model_n(rnd_q[i]) != 0) ? rnd_q[i] : 128'd0) ||
                longint'(rec_len[base + i]) != model_n(rnd_q[i]) || rec_bad[base + i] ||
                rec_g2l[base + i] != rnd_q[i][5] || rec_g2s[base + i] != rnd_q[i][6]) begin
                err++;
                $display("FAIL rnd_rec%0d got=%h/%0d/%0b%0b exp=%h/%0d/%0b%0b", i, rec_val[base + i],
                         rec_len[base + i], rec_g2l[base + i], rec_g2s[base + i], rnd_q[i],
                         model_n(rnd_q[i]), rnd_q[i][5], rnd_q[i][6]);
            end
        end
        chk++;
        if (l2g_pulses - l0 != exp_l || s2g_pulses - s0 != exp_s) begin
            err++;
            $display("FAIL rnd_pops got=%0d/%0d exp=%0d/%0d", l2g_pulses - l0, s2g_pulses - s0, exp_l, exp_s);
        end
    endtask

    initial begin
        rst = 1'b0; insn_in = '0; insn_valid = 1'b0;
        l2g_dep_valid = 1'b0; s2g_dep_valid = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_gemm_exec;
        test_dep_wait;
        test_zero_len;
        test_non_gemm;
        test_back_to_back;
        test_reset_mid_exec;
        test_random;
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
